sound_priority_synth: RTL and testbench

- Parametrised N-channel square-wave tone synthesiser for the car-simulator audio path.
- Generalises the fixed horn/click/melody/engine mux into generic channels, each with:
  - a programmable half-period;
  - a held (level) request;
  - a retriggerable one-shot timer.
- Fixed priority: channel 0 is highest.
- Drives the single piezo pin. Upstream blocks (horn, indicator, reverse-melody sequencer, engine-RPM mapper) only supply periods and requests.

---
 rtl/sound_priority_synth.sv | 130 +++++++++++++
 tb/tb_sound_priority_synth.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sound_priority_synth.sv
// sound_priority_synth: N-channel fixed-priority square-wave tone synthesiser
// driving a single piezo pin. Each channel plays while its level request is
// held or its retriggerable one-shot timer is running, provided its
// half-period is non-zero. Channel 0 has the highest priority.
module sound_priority_synth #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 20,
  parameter int LEN_W    = 24,
  parameter int CH_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH-1:0]          trig,
  input  logic [NUM_CH*PERIOD_W-1:0] period,
  input  logic [NUM_CH*LEN_W-1:0]    shot_len,
  output logic                       tone_out,
  output logic                       active_valid,
  output logic [CH_W-1:0]            active_ch,
  output logic [NUM_CH-1:0]          shot_busy
);

  // One-shot timers and their registered busy flags
  logic [LEN_W-1:0]    shot_q [NUM_CH];
  logic [LEN_W-1:0]    shot_d [NUM_CH];
  logic [NUM_CH-1:0]   busy_q, busy_d;

  // Per-channel half-periods unpacked from the bus
  logic [PERIOD_W-1:0] per_a [NUM_CH];
  logic [NUM_CH-1:0]   pend;

  // Arbitration result and winner register
  logic                any_pend;
  logic [CH_W-1:0]     win;
  logic                av_q, av_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                switch_w;

  // Shared tone counter and output phase
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                tone_q, tone_d;
  logic [PERIOD_W-1:0] cur_per;

  // Timer next-state: a non-zero trigger length reloads, otherwise count down to zero
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      shot_d[i] = shot_q[i];
      if (trig[i] && (shot_len[i*LEN_W +: LEN_W] != '0)) begin
        shot_d[i] = shot_len[i*LEN_W +: LEN_W];
      end else if (shot_q[i] != '0) begin
        shot_d[i] = shot_q[i] - LEN_W'(1);
      end
      busy_d[i] = (shot_d[i] != '0);
    end
  end

  // Pending vector: a channel with a zero half-period never competes
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      per_a[i] = period[i*PERIOD_W +: PERIOD_W];
      pend[i]  = (req[i] | busy_q[i]) & (per_a[i] != '0);
    end
  end

  // Fixed-priority pick: scanning downward leaves the lowest pending index
  always_comb begin
    any_pend = 1'b0;
    win      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        any_pend = 1'b1;
        win      = CH_W'(i);
      end
    end
    av_d     = any_pend;
    ch_d     = any_pend ? win : ch_q;
    switch_w = any_pend & (~av_q | (win != ch_q));
  end

  // Tone counter: restart on owner change, clear while muted, else count and toggle
  always_comb begin
    cur_per = per_a[ch_q];
    cnt_d   = '0;
    tone_d  = 1'b0;
    if (switch_w) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (av_q && en) begin
      // Compare as cnt+1 >= period so a period shrunk below the count wraps next cycle
      if (({1'b0, cnt_q} + (PERIOD_W+1)'(1)) >= {1'b0, cur_per}) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d  = cnt_q + PERIOD_W'(1);
        tone_d = tone_q;
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shot_q[i] <= '0;
      end
      busy_q <= '0;
      av_q   <= 1'b0;
      ch_q   <= '0;
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        shot_q[i] <= shot_d[i];
      end
      busy_q <= busy_d;
      av_q   <= av_d;
      ch_q   <= ch_d;
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  // Gate with en and ownership so muting takes effect in the same cycle
  assign tone_out     = tone_q & en & av_q;
  assign active_valid = av_q;
  assign active_ch    = ch_q;
  assign shot_busy    = busy_q;

endmodule

// File: tb/tb_sound_priority_synth.sv
// Scoreboarded bench for sound_priority_synth: directed scenarios plus
// randomized traffic, compared against a behavioural model of the channels.
module tb_sound_priority_synth;

  localparam int NCH = 4;
  localparam int PW  = 20;
  localparam int LW  = 24;
  localparam int CW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [NCH-1:0]      req;
  logic [NCH-1:0]      trig;
  logic [NCH*PW-1:0]   period;
  logic [NCH*LW-1:0]   shot_len;
  logic                tone_out;
  logic                active_valid;
  logic [CW-1:0]       active_ch;
  logic [NCH-1:0]      shot_busy;

  sound_priority_synth #(
    .NUM_CH(NCH), .PERIOD_W(PW), .LEN_W(LW), .CH_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .trig(trig),
    .period(period), .shot_len(shot_len), .tone_out(tone_out),
    .active_valid(active_valid), .active_ch(active_ch), .shot_busy(shot_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           tone;
    logic           av;
    logic [CW-1:0]  ch;
    logic [NCH-1:0] busy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model state: remaining one-shot cycles, owner, half-period progress
  int m_t [NCH];
  bit m_av;
  int m_ch;
  int m_run;
  bit m_lvl;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic int per(input int i);
    return int'(period[i*PW +: PW]);
  endfunction

  function automatic int slen(input int i);
    return int'(shot_len[i*LW +: LW]);
  endfunction

  task automatic set_per(input int ch, input int v);
    period[ch*PW +: PW] = PW'(v);
  endtask

  task automatic set_len(input int ch, input int v);
    shot_len[ch*LW +: LW] = LW'(v);
  endtask

  // Advance the model by the clock edge that will capture the current inputs
  task automatic model_push();
    exp_t e;
    int   w;
    bit   p;
    if (!rst) begin
      for (int i = 0; i < NCH; i++) m_t[i] = 0;
      m_av = 0; m_ch = 0; m_run = 0; m_lvl = 0;
    end else begin
      w = -1;
      for (int i = 0; i < NCH; i++) begin
        p = (req[i] || (m_t[i] != 0)) && (per(i) != 0);
        if (p && w < 0) w = i;
      end
      if (w >= 0 && (!m_av || w != m_ch)) begin
        m_run = 0; m_lvl = 0;
      end else if (m_av && en) begin
        m_run++;
        if (m_run >= per(m_ch)) begin
          m_run = 0; m_lvl = !m_lvl;
        end
      end else begin
        m_run = 0; m_lvl = 0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (trig[i] && slen(i) != 0) m_t[i] = slen(i);
        else if (m_t[i] > 0) m_t[i]--;
      end
      m_av = (w >= 0);
      if (w >= 0) m_ch = w;
    end
    e.tone = m_lvl && en && m_av;
    e.av   = m_av;
    e.ch   = CW'(m_ch);
    for (int i = 0; i < NCH; i++) e.busy[i] = (m_t[i] != 0);
    sb.push_back(e);
  endtask

  task automatic apply(input int n = 1);
    repeat (n) begin
      model_push();
      @(negedge clk);
    end
  endtask

  // Monitor: compare DUT outputs shortly after each active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("tone_out", int'(tone_out), int'(mon_e.tone));
        chk("active_valid", int'(active_valid), int'(mon_e.av));
        chk("active_ch", int'(active_ch), int'(mon_e.ch));
        chk("shot_busy", int'(shot_busy), int'(mon_e.busy));
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b1; req = 4'b0001; trig = '0;
    period = '0; shot_len = '0;
    set_per(0, 4);
    #2;
    chk("reset_tone", int'(tone_out), 0);
    chk("reset_valid", int'(active_valid), 0);
    chk("reset_ch", int'(active_ch), 0);
    chk("reset_busy", int'(shot_busy), 0);
    @(negedge clk);
    apply(3);
    // Scenario 1: single channel, half-period 4
    rst = 1'b1;
    apply(30);

    // Scenario 2: preemption by channel 0 and return to channel 2
    req = 4'b0100; set_per(2, 10);
    apply(50);
    req = 4'b0101; set_per(0, 3);
    apply(20);
    req = 4'b0100;
    apply(25);

    // Scenario 3: one-shot, retrigger, zero length
    req = 4'b0000; set_per(1, 2); set_len(1, 20);
    trig = 4'b0010; apply(); trig = '0;
    apply(5);
    trig = 4'b0010; apply(); trig = '0;
    apply(25);
    set_len(1, 0);
    trig = 4'b0010; apply(); trig = '0;
    apply(5);

    // Scenario 4: zero half-period excludes channel 0
    req = 4'b0011; set_per(0, 0); set_per(1, 5);
    apply(25);

    // Scenario 5: mute and re-enable
    req = 4'b0001; set_per(0, 6);
    apply(15);
    en = 1'b0; apply(30);
    en = 1'b1; apply(20);

    // Scenario 6: asynchronous reset mid-tone and mid-one-shot
    req = 4'b0100; set_per(2, 3); set_per(3, 5); set_len(3, 40);
    trig = 4'b1000; apply(); trig = '0;
    apply(10);
    rst = 1'b0;
    #1;
    chk("async_rst_tone", int'(tone_out), 0);
    chk("async_rst_valid", int'(active_valid), 0);
    chk("async_rst_busy", int'(shot_busy), 0);
    apply(2);
    rst = 1'b1;
    apply(15);

    // Randomized traffic with non-zero half-periods
    for (int i = 0; i < NCH; i++) set_per(i, 3 + i);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) req = NCH'($urandom);
      trig = '0;
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 7) == 0) trig[i] = 1'b1;
      if ($urandom_range(0, 5) == 0) set_len(int'($urandom_range(0, NCH-1)), int'($urandom_range(0, 30)));
      if ($urandom_range(0, 11) == 0) set_per(int'($urandom_range(0, NCH-1)), int'($urandom_range(1, 12)));
      if ($urandom_range(0, 24) == 0) en = !en;
      apply();
    end
    trig = '0; en = 1'b1;
    apply(10);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
